// File: rtl/stat_upd_sched_if.sv
// Stat-check job inputs, counter-RAM port and status outputs of stat_upd_sched.
interface stat_upd_sched_if #(
    parameter int CNT_W = 32,
    parameter int AW    = 11
);
    logic             tx_stat_chk;
    logic [3:0]       tx_stat_base_addr;
    logic [63:0]      tx_stat_bit;
    logic             rx_stat_chk;
    logic [3:0]       rx_stat_base_addr;
    logic [63:0]      rx_stat_bit;
    logic             clr_in;
    logic             clr_done;
    logic [AW-1:0]    ram_addr;
    logic             ram_rd;
    logic [CNT_W-1:0] ram_rdata;
    logic             ram_wr;
    logic [CNT_W-1:0] ram_wdata;
    logic             tx_drop;
    logic             rx_drop;
    logic             busy;

    modport slave (
        input  tx_stat_chk, tx_stat_base_addr, tx_stat_bit,
        input  rx_stat_chk, rx_stat_base_addr, rx_stat_bit,
        input  clr_in, ram_rdata,
        output clr_done, ram_addr, ram_rd, ram_wr, ram_wdata,
        output tx_drop, rx_drop, busy
    );

    modport master (
        output tx_stat_chk, tx_stat_base_addr, tx_stat_bit,
        output rx_stat_chk, rx_stat_base_addr, rx_stat_bit,
        output clr_in, ram_rdata,
        input  clr_done, ram_addr, ram_rd, ram_wr, ram_wdata,
        input  tx_drop, rx_drop, busy
    );
endinterface

// File: rtl/stat_upd_sched.sv
// Buffers TX/RX stat jobs, round-robins them into read-modify-write increments
// on a single-port counter RAM, and sequences the full-RAM clear sweep.
module stat_upd_sched #(
    parameter int CNT_W = 32,
    parameter int AW    = 11
) (
    input logic             clk,
    input logic             rst_n,
    stat_upd_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WB, CLR} state_t;

    state_t           state_q;
    logic             rr_q, side_q, clr_req_q, rd_q, wr_q, clr_done_q;
    logic [3:0]       base_q;
    logic [63:0]      work_q;
    logic [AW-1:0]    addr_q;

    // Per-side job buffers: index 0 = TX, 1 = RX
    logic [1:0]       vld_q, vld_d, drop_q, drop_d, rel, chk;
    logic [1:0][3:0]  bbase_q, bbase_d, chk_base;
    logic [1:0][63:0] bmask_q, bmask_d, chk_mask;

    logic             pick, job_go, clr_fin;
    logic [63:0]      work_nxt, lsb_src;
    logic [5:0]       idx_nxt;

    function automatic logic [5:0] lsb_idx(input logic [63:0] m);
        logic [5:0] r;
        r = '0;
        for (int i = 63; i >= 0; i--)
            if (m[i]) r = 6'(i);
        return r;
    endfunction

    assign chk      = {bus.rx_stat_chk, bus.tx_stat_chk};
    assign chk_base = {bus.rx_stat_base_addr, bus.tx_stat_base_addr};
    assign chk_mask = {bus.rx_stat_bit, bus.tx_stat_bit};

    always_comb begin
        job_go   = (state_q == IDLE) && !clr_req_q && (vld_q != 2'b00);
        pick     = (vld_q == 2'b11) ? rr_q : vld_q[1];
        work_nxt = work_q & (work_q - 64'd1);
        lsb_src  = (state_q == IDLE) ? bmask_q[pick] : work_nxt;
        idx_nxt  = lsb_idx(lsb_src);
        clr_fin  = (state_q == CLR) && (addr_q == '1);
        rel      = '0;
        if (job_go && (bmask_q[pick] == '0)) rel[pick] = 1'b1;
        if ((state_q == WB) && (work_nxt == '0)) rel[side_q] = 1'b1;
    end

    // Release happens before capture so a chk in the release cycle is accepted
    always_comb begin
        vld_d   = vld_q & ~rel;
        bbase_d = bbase_q;
        bmask_d = bmask_q;
        drop_d  = clr_fin ? 2'b00 : drop_q;
        for (int s = 0; s < 2; s++) begin
            if (chk[s]) begin
                if (!vld_d[s]) begin
                    vld_d[s]   = 1'b1;
                    bbase_d[s] = chk_base[s];
                    bmask_d[s] = chk_mask[s];
                end else begin
                    drop_d[s]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q   <= '0;
            drop_q  <= '0;
            bbase_q <= '0;
            bmask_q <= '0;
        end else begin
            vld_q   <= vld_d;
            drop_q  <= drop_d;
            bbase_q <= bbase_d;
            bmask_q <= bmask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            side_q     <= 1'b0;
            base_q     <= '0;
            work_q     <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            clr_done_q <= 1'b0;
            clr_req_q  <= 1'b0;
        end else begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            clr_done_q <= 1'b0;
            if ((state_q == IDLE) && clr_req_q)
                clr_req_q <= 1'b0;
            else if (bus.clr_in && (state_q != CLR))
                clr_req_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (clr_req_q) begin
                        state_q <= CLR;
                        wr_q    <= 1'b1;
                        addr_q  <= '0;
                    end else if (job_go) begin
                        if (vld_q == 2'b11) rr_q <= ~pick;
                        if (bmask_q[pick] != '0) begin
                            state_q <= RD;
                            rd_q    <= 1'b1;
                            side_q  <= pick;
                            base_q  <= bbase_q[pick];
                            work_q  <= bmask_q[pick];
                            addr_q  <= {pick, bbase_q[pick], idx_nxt};
                        end
                    end
                end
                RD: begin
                    state_q <= WB;
                    wr_q    <= 1'b1;
                end
                WB: begin
                    work_q <= work_nxt;
                    if (work_nxt == '0) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= RD;
                        rd_q    <= 1'b1;
                        addr_q  <= {side_q, base_q, idx_nxt};
                    end
                end
                CLR: begin
                    if (clr_fin) begin
                        state_q    <= IDLE;
                        clr_done_q <= 1'b1;
                    end else begin
                        wr_q   <= 1'b1;
                        addr_q <= addr_q + {{(AW-1){1'b0}}, 1'b1};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ram_addr  = addr_q;
    assign bus.ram_rd    = rd_q;
    assign bus.ram_wr    = wr_q;
    assign bus.ram_wdata = (state_q == WB) ? bus.ram_rdata + {{(CNT_W-1){1'b0}}, 1'b1} : '0;
    assign bus.clr_done  = clr_done_q;
    assign bus.tx_drop   = drop_q[0];
    assign bus.rx_drop   = drop_q[1];
    assign bus.busy      = (state_q != IDLE) || (vld_q != 2'b00) || clr_req_q;
endmodule

// File: tb/tb_stat_upd_sched.sv
// Directed bench for stat_upd_sched with a one-cycle-latency RAM model.
module tb_stat_upd_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stat_upd_sched_if bus();
    stat_upd_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    logic [31:0] mem [0:2047];
    logic [42:0] wlog [$];
    logic        pl_en = 1'b0;
    logic [10:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    int clr_done_cnt = 0;
    int both_cnt = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus.ram_wr) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            wlog.push_back({bus.ram_addr, bus.ram_wdata});
        end
        if (bus.ram_rd) bus.ram_rdata <= mem[bus.ram_addr];
        if (bus.clr_done) clr_done_cnt++;
        if (bus.ram_rd && bus.ram_wr) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [42:0] wl(input int i);
        if (i < wlog.size()) return wlog[i];
        return 'x;
    endfunction

    task automatic preload(input logic [10:0] a, input logic [31:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic send(input logic tx, input logic [3:0] tb, input logic [63:0] tm,
                        input logic rx, input logic [3:0] rb, input logic [63:0] rm);
        bus.tx_stat_chk = tx; bus.tx_stat_base_addr = tb; bus.tx_stat_bit = tm;
        bus.rx_stat_chk = rx; bus.rx_stat_base_addr = rb; bus.rx_stat_bit = rm;
        tick();
        bus.tx_stat_chk = 1'b0; bus.rx_stat_chk = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (bus.busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({bus.ram_rd, bus.ram_wr, bus.clr_done, bus.tx_drop, bus.rx_drop, bus.busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {bus.ram_rd, bus.ram_wr, bus.clr_done, bus.tx_drop, bus.rx_drop, bus.busy});
        end
        checks++;
        if (bus.ram_addr !== 11'h000) begin
            errors++; $display("FAIL reset_addr: got %h want 000", bus.ram_addr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n, b;
        preload(11'h0C0, 32'd7);
        preload(11'h0C2, 32'd7);
        b = wlog.size();
        send(1'b1, 4'd3, 64'h5, 1'b0, 4'd0, 64'h0);
        wait_idle(100, n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL basic_busy: got %0d want 5", n); end
        checks++;
        if (wl(b) !== {11'h0C0, 32'd8}) begin errors++; $display("FAIL basic_w0: got %h want %h", wl(b), {11'h0C0, 32'd8}); end
        checks++;
        if (wl(b+1) !== {11'h0C2, 32'd8}) begin errors++; $display("FAIL basic_w1: got %h want %h", wl(b+1), {11'h0C2, 32'd8}); end
        checks++;
        if (wlog.size() - b !== 2) begin errors++; $display("FAIL basic_cnt: got %0d want 2", wlog.size() - b); end
    endtask

    task automatic test_rr();
        int n, b;
        preload(11'h000, 32'd10);
        preload(11'h400, 32'd20);
        b = wlog.size();
        send(1'b1, 4'd0, 64'h1, 1'b1, 4'd0, 64'h1);
        wait_idle(100, n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL rr_busy: got %0d want 6", n); end
        checks++;
        if (wl(b) !== {11'h000, 32'd11}) begin errors++; $display("FAIL rr_first_tx: got %h want %h", wl(b), {11'h000, 32'd11}); end
        checks++;
        if (wl(b+1) !== {11'h400, 32'd21}) begin errors++; $display("FAIL rr_then_rx: got %h want %h", wl(b+1), {11'h400, 32'd21}); end
        send(1'b1, 4'd0, 64'h1, 1'b1, 4'd0, 64'h1);
        wait_idle(100, n);
        checks++;
        if (wl(b+2) !== {11'h400, 32'd22}) begin errors++; $display("FAIL rr_first_rx: got %h want %h", wl(b+2), {11'h400, 32'd22}); end
        checks++;
        if (wl(b+3) !== {11'h000, 32'd12}) begin errors++; $display("FAIL rr_then_tx: got %h want %h", wl(b+3), {11'h000, 32'd12}); end
    endtask

    task automatic test_drop();
        int n, b;
        preload(11'h080, 32'd0);
        preload(11'h081, 32'd0);
        preload(11'h084, 32'd0);
        preload(11'h140, 32'd0);
        b = wlog.size();
        send(1'b1, 4'd2, 64'h3, 1'b0, 4'd0, 64'h0);
        repeat (4) tick();
        checks++;
        if (bus.ram_wr !== 1'b1) begin errors++; $display("FAIL release_cycle_wb: got %b want 1", bus.ram_wr); end
        send(1'b1, 4'd2, 64'h10, 1'b0, 4'd0, 64'h0);
        checks++;
        if (bus.tx_drop !== 1'b0) begin errors++; $display("FAIL release_no_drop: got %b want 0", bus.tx_drop); end
        wait_idle(100, n);
        checks++;
        if (wl(b+2) !== {11'h084, 32'd1} || wlog.size() - b !== 3) begin
            errors++; $display("FAIL release_accept: got %h n=%0d want %h n=3", wl(b+2), wlog.size() - b, {11'h084, 32'd1});
        end
        b = wlog.size();
        send(1'b1, 4'd5, 64'h1, 1'b0, 4'd0, 64'h0);
        send(1'b1, 4'd5, 64'h2, 1'b0, 4'd0, 64'h0);
        checks++;
        if ({bus.tx_drop, bus.rx_drop} !== 2'b10) begin errors++; $display("FAIL drop_flag: got %b want 10", {bus.tx_drop, bus.rx_drop}); end
        wait_idle(100, n);
        checks++;
        if (wl(b) !== {11'h140, 32'd1} || wlog.size() - b !== 1) begin
            errors++; $display("FAIL drop_lost: got %h n=%0d want %h n=1", wl(b), wlog.size() - b, {11'h140, 32'd1});
        end
    endtask

    task automatic test_wrap();
        int n, b;
        preload(11'h7FF, 32'hFFFF_FFFF);
        b = wlog.size();
        send(1'b0, 4'd0, 64'h0, 1'b1, 4'hF, 64'h8000_0000_0000_0000);
        wait_idle(100, n);
        checks++;
        if (wl(b) !== {11'h7FF, 32'd0}) begin errors++; $display("FAIL wrap: got %h want %h", wl(b), {11'h7FF, 32'd0}); end
        b = wlog.size();
        send(1'b1, 4'd1, 64'h0, 1'b0, 4'd0, 64'h0);
        wait_idle(100, n);
        checks++;
        if (n !== 1 || wlog.size() !== b) begin
            errors++; $display("FAIL zero_mask: got busy=%0d writes=%0d want busy=1 writes=0", n, wlog.size() - b);
        end
    endtask

    task automatic test_clear();
        int n, b, d0, bad;
        preload(11'h040, 32'd100);
        preload(11'h041, 32'd100);
        preload(11'h042, 32'd100);
        b = wlog.size();
        d0 = clr_done_cnt;
        send(1'b1, 4'd1, 64'h7, 1'b0, 4'd0, 64'h0);
        tick();
        bus.clr_in = 1'b1; tick(); bus.clr_in = 1'b0;
        repeat (100) tick();
        bus.clr_in = 1'b1; tick(); bus.clr_in = 1'b0;
        wait_idle(5000, n);
        tick(); tick();
        checks++;
        if (n >= 5000) begin errors++; $display("FAIL clr_timeout: got %0d cycles want <5000", n); end
        checks++;
        if (wl(b) !== {11'h040, 32'd101} || wl(b+1) !== {11'h041, 32'd101} || wl(b+2) !== {11'h042, 32'd101}) begin
            errors++; $display("FAIL clr_job_first: got %h %h %h want 040/041/042 data 101", wl(b), wl(b+1), wl(b+2));
        end
        bad = 0;
        for (int i = 0; i < 2048; i++)
            if (wl(b+3+i) !== {11'(i), 32'd0}) bad++;
        checks++;
        if (bad !== 0 || wlog.size() - b !== 2051) begin
            errors++; $display("FAIL clr_sweep: got %0d bad, %0d writes want 0 bad, 2051 writes", bad, wlog.size() - b);
        end
        checks++;
        if (clr_done_cnt - d0 !== 1) begin errors++; $display("FAIL clr_done: got %0d pulses want 1", clr_done_cnt - d0); end
        checks++;
        if ({bus.tx_drop, bus.rx_drop} !== 2'b00) begin errors++; $display("FAIL clr_drops: got %b want 00", {bus.tx_drop, bus.rx_drop}); end
    endtask

    task automatic test_reset_mid();
        int b, d0;
        d0 = clr_done_cnt;
        send(1'b1, 4'd4, 64'h3, 1'b0, 4'd0, 64'h0);
        tick(); tick();
        checks++;
        if (bus.ram_wr !== 1'b1) begin errors++; $display("FAIL rst_mid_wb_state: got %b want 1", bus.ram_wr); end
        rst_n = 1'b0; tick();
        checks++;
        if ({bus.ram_rd, bus.ram_wr, bus.busy} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_strobes: got %b want 000", {bus.ram_rd, bus.ram_wr, bus.busy});
        end
        rst_n = 1'b1;
        b = wlog.size();
        repeat (10) tick();
        checks++;
        if (wlog.size() !== b) begin errors++; $display("FAIL rst_mid_job_writes: got %0d want 0", wlog.size() - b); end
        bus.clr_in = 1'b1; tick(); bus.clr_in = 1'b0;
        repeat (50) tick();
        rst_n = 1'b0; tick();
        checks++;
        if (bus.ram_wr !== 1'b0) begin errors++; $display("FAIL rst_clr_wr: got %b want 0", bus.ram_wr); end
        rst_n = 1'b1;
        b = wlog.size();
        repeat (20) tick();
        checks++;
        if (wlog.size() !== b || clr_done_cnt !== d0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_clr_abandon: got writes=%0d done=%0d busy=%b want 0 0 0",
                               wlog.size() - b, clr_done_cnt - d0, bus.busy);
        end
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL rd_wr_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        bus.tx_stat_chk = 1'b0; bus.tx_stat_base_addr = '0; bus.tx_stat_bit = '0;
        bus.rx_stat_chk = 1'b0; bus.rx_stat_base_addr = '0; bus.rx_stat_bit = '0;
        bus.clr_in = 1'b0;
        test_reset();
        test_basic();
        test_rr();
        test_drop();
        test_wrap();
        test_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
